miriscv_rst_seq: RTL and testbench

MIRISCV_RST_SEQ -- requirements
Module: miriscv_rst_seq

---
 rtl/miriscv_tb_pkg.sv | 30 +++
 rtl/miriscv_sat_counter.sv | 41 ++++
 rtl/miriscv_rst_seq.sv | 155 +++++++++++++++
 tb/tb_miriscv_rst_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/miriscv_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_tb_pkg
// Description : Shared types, parameter defaults and helpers for the reset
//               sequencer and its counters.
// Revision    : 1.0 - initial release
// ============================================================================
package miriscv_tb_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int c_NUM_CH_DEF         = 2;
    localparam int c_HOLD_CYCLES_DEF    = 4;
    localparam int c_STAGGER_CYCLES_DEF = 2;
    localparam int c_CNT_W_DEF          = 32;
    localparam int c_TIMEOUT_CYCLES_DEF = 0;

    // Timer width large enough to reach the last channel release time.
    function automatic int rel_time_w(input int hold, input int nch, input int stag);
        return $clog2(hold + nch * stag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_sat_counter
// Description : Up-counter that sticks at all-ones; clear beats count.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             frozen_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (clear_i) begin
            w_count_d = '0;
        end else if (enable_i && !frozen_i && (r_count_q != '1)) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count_o = r_count_q;

endmodule
`default_nettype wire

// File: rtl/miriscv_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_rst_seq
// Description : Staggered multi-channel reset release with run-cycle counter,
//               halt detection and optional watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_rst_seq
    import miriscv_tb_pkg::*;
#(
    parameter int NUM_CH         = c_NUM_CH_DEF,
    parameter int HOLD_CYCLES    = c_HOLD_CYCLES_DEF,
    parameter int STAGGER_CYCLES = c_STAGGER_CYCLES_DEF,
    parameter int CNT_W          = c_CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              soft_rst_req_i,
    input  logic              halt_i,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic [NUM_CH-1:0] ch_rst_n_o,
    output logic [CNT_W-1:0]  run_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    generate
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("NUM_CH must be in 1..8");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("HOLD_CYCLES must be at least 1");
        end
        if (STAGGER_CYCLES < 1) begin : g_bad_stagger
            $error("STAGGER_CYCLES must be at least 1");
        end
        if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
            $error("CNT_W must be in 1..64");
        end
        if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must not be negative");
        end
    endgenerate

    localparam int c_TW        = rel_time_w(HOLD_CYCLES, NUM_CH, STAGGER_CYCLES);
    localparam int c_HOLD_LAST = HOLD_CYCLES - 1;
    localparam int c_LAST_REL  = HOLD_CYCLES - 1 + (NUM_CH - 1) * STAGGER_CYCLES;

    state_e            r_state_q, w_state_d;
    logic [NUM_CH-1:0] r_ch_rst_q, w_ch_rst_d, r_ch_rst_n_q;
    logic              r_busy_q, w_busy_d;
    logic              r_done_q, w_done_d;
    logic              r_timeout_q, w_timeout_d;
    logic [c_TW-1:0]   w_timer;
    logic [CNT_W-1:0]  w_run_cnt;
    logic              w_seq_active;
    logic              w_timeout_hit;

    assign w_seq_active  = (r_state_q == ST_HOLD) || (r_state_q == ST_RELEASE);
    // Fires on the cycle whose increment would land exactly on the limit.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                           (64'(w_run_cnt) == (64'(TIMEOUT_CYCLES) - 64'd1));

    // Elapsed cycles since reset end; its value selects each release edge.
    miriscv_sat_counter #(
        .WIDTH (c_TW)
    ) u_seq_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (soft_rst_req_i),
        .enable_i (1'b1),
        .frozen_i (!w_seq_active),
        .count_o  (w_timer)
    );

    miriscv_sat_counter #(
        .WIDTH (CNT_W)
    ) u_run_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (soft_rst_req_i),
        .enable_i (r_state_q == ST_RUN),
        .frozen_i ((r_state_q == ST_DONE) || (r_state_q == ST_TIMEOUT)),
        .count_o  (w_run_cnt)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_ch_rst_d = r_ch_rst_q;
        case (r_state_q)
            ST_HOLD: begin
                if (w_timer == c_TW'(c_HOLD_LAST)) begin
                    w_ch_rst_d[0] = 1'b0;
                    w_state_d     = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                for (int k = 1; k < NUM_CH; k++) begin
                    if (w_timer == c_TW'(c_HOLD_LAST + k * STAGGER_CYCLES)) begin
                        w_ch_rst_d[k] = 1'b0;
                    end
                end
                if (w_timer == c_TW'(c_LAST_REL)) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Halt is checked first so it wins a tie with the watchdog.
                if (halt_i) begin
                    w_state_d = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_state_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (soft_rst_req_i) begin
            w_state_d  = ST_HOLD;
            w_ch_rst_d = '1;
        end
    end

    assign w_busy_d    = (w_state_d == ST_HOLD) || (w_state_d == ST_RELEASE);
    assign w_done_d    = (w_state_d == ST_DONE);
    assign w_timeout_d = (w_state_d == ST_TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= ST_HOLD;
            r_ch_rst_q   <= '1;
            r_ch_rst_n_q <= '0;
            r_busy_q     <= 1'b1;
            r_done_q     <= 1'b0;
            r_timeout_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_ch_rst_q   <= w_ch_rst_d;
            r_ch_rst_n_q <= ~w_ch_rst_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
            r_timeout_q  <= w_timeout_d;
        end
    end

    assign ch_rst_o   = r_ch_rst_q;
    assign ch_rst_n_o = r_ch_rst_n_q;
    assign run_cnt_o  = w_run_cnt;
    assign busy_o     = r_busy_q;
    assign done_o     = r_done_q;
    assign timeout_o  = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_miriscv_rst_seq
// Description : Scoreboard bench for two sequencer configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_rst_seq;

    typedef struct {
        int          edge_n;
        int          dut;
        string       name;
        logic [2:0]  ch;
        logic        busy;
        logic        done;
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_a, halt_a, soft_b, halt_b;
    logic [2:0]  a_ch, a_chn;
    logic [31:0] a_cnt;
    logic        a_busy, a_done, a_tmo;
    logic [0:0]  b_ch, b_chn;
    logic [3:0]  b_cnt;
    logic        b_busy, b_done, b_tmo;

    exp_t q[$];
    int   edge_no = 0;
    int   n_vec   = 0;
    int   n_err   = 0;

    always #5 clk = ~clk;

    miriscv_rst_seq #(
        .NUM_CH(3), .HOLD_CYCLES(4), .STAGGER_CYCLES(2), .CNT_W(32), .TIMEOUT_CYCLES(16)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .soft_rst_req_i(soft_a), .halt_i(halt_a),
        .ch_rst_o(a_ch), .ch_rst_n_o(a_chn), .run_cnt_o(a_cnt),
        .busy_o(a_busy), .done_o(a_done), .timeout_o(a_tmo)
    );

    miriscv_rst_seq #(
        .NUM_CH(1), .HOLD_CYCLES(4), .STAGGER_CYCLES(1), .CNT_W(4), .TIMEOUT_CYCLES(0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .soft_rst_req_i(soft_b), .halt_i(halt_b),
        .ch_rst_o(b_ch), .ch_rst_n_o(b_chn), .run_cnt_o(b_cnt),
        .busy_o(b_busy), .done_o(b_done), .timeout_o(b_tmo)
    );

    function automatic void ex(input int e, input int d, input string n, input logic [2:0] ch,
                               input logic b, input logic dn, input logic t, input int c);
        exp_t x;
        x.edge_n = e; x.dut = d; x.name = n; x.ch = ch;
        x.busy = b; x.done = dn; x.tmo = t; x.cnt = 32'(c);
        q.push_back(x);
    endfunction

    task automatic check(input exp_t x);
        logic [2:0]  ch, chn;
        logic        bz, dn, tm;
        logic [31:0] cnt;
        if (x.dut == 0) begin
            ch = a_ch; chn = a_chn; bz = a_busy; dn = a_done; tm = a_tmo; cnt = a_cnt;
        end else begin
            ch = {2'b00, b_ch}; chn = {2'b11, b_chn}; bz = b_busy; dn = b_done; tm = b_tmo;
            cnt = {28'd0, b_cnt};
        end
        n_vec++;
        if (ch !== x.ch || chn !== ~x.ch || bz !== x.busy || dn !== x.done ||
            tm !== x.tmo || cnt !== x.cnt) begin
            n_err++;
            $display("FAIL %s @edge %0d: got ch=%b chn=%b busy=%b done=%b tmo=%b cnt=%0d, want ch=%b chn=%b busy=%b done=%b tmo=%b cnt=%0d",
                     x.name, edge_no, ch, chn, bz, dn, tm, cnt,
                     x.ch, ~x.ch, x.busy, x.done, x.tmo, x.cnt);
        end
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].edge_n == edge_no) begin
                    check(q[i]);
                    q.delete(i);
                end
            end
        end
    end

    task automatic goto(input int e);
        while (edge_no < e) @(negedge clk);
    endtask

    initial begin
        int r, s, s2, qr, p, q2, z;
        rst = 1'b1; soft_a = 1'b0; halt_a = 1'b0; soft_b = 1'b0; halt_b = 1'b0;
        r = 3; s = r + 40; s2 = s + 5; qr = s2 + 8; p = qr + 30; q2 = p + 8; z = q2 + 25;

        ex(r, 0, "a_reset", 3'b111, 1, 0, 0, 0);
        ex(r, 1, "b_reset", 3'b001, 1, 0, 0, 0);
        ex(r + 2, 0, "a_hold_halt_ignored", 3'b111, 1, 0, 0, 0);
        ex(r + 3, 0, "a_hold_end", 3'b111, 1, 0, 0, 0);
        ex(r + 4, 0, "a_ch0_rel", 3'b110, 1, 0, 0, 0);
        ex(r + 5, 0, "a_ch1_held", 3'b110, 1, 0, 0, 0);
        ex(r + 6, 0, "a_ch1_rel", 3'b100, 1, 0, 0, 0);
        ex(r + 7, 0, "a_ch2_held", 3'b100, 1, 0, 0, 0);
        ex(r + 8, 0, "a_run_entry", 3'b000, 0, 0, 0, 0);
        ex(r + 17, 0, "a_run9", 3'b000, 0, 0, 0, 9);
        ex(r + 18, 0, "a_halt_done", 3'b000, 0, 1, 0, 10);
        ex(r + 38, 0, "a_done_stable", 3'b000, 0, 1, 0, 10);
        ex(r + 3, 1, "b_hold_end", 3'b001, 1, 0, 0, 0);
        ex(r + 4, 1, "b_single_ch_run", 3'b000, 0, 0, 0, 0);
        ex(r + 5, 1, "b_run1", 3'b000, 0, 0, 0, 1);
        ex(r + 19, 1, "b_run15", 3'b000, 0, 0, 0, 15);
        ex(r + 20, 1, "b_saturated", 3'b000, 0, 0, 0, 15);
        ex(r + 30, 1, "b_sat_stable", 3'b000, 0, 0, 0, 15);
        ex(s - 1, 0, "a_done_before_soft", 3'b000, 0, 1, 0, 10);
        ex(s, 0, "a_soft_from_done", 3'b111, 1, 0, 0, 0);
        ex(s + 4, 0, "a_soft_ch0_rel", 3'b110, 1, 0, 0, 0);
        ex(s2, 0, "a_soft_in_release", 3'b111, 1, 0, 0, 0);
        ex(s2 + 3, 0, "a_replay_hold", 3'b111, 1, 0, 0, 0);
        ex(s2 + 4, 0, "a_replay_ch0", 3'b110, 1, 0, 0, 0);
        ex(s2 + 6, 0, "a_replay_ch1", 3'b100, 1, 0, 0, 0);
        ex(s2 + 7, 0, "a_replay_ch2_held", 3'b100, 1, 0, 0, 0);
        ex(qr, 0, "a_replay_run", 3'b000, 0, 0, 0, 0);
        ex(qr + 15, 0, "a_wd_pre", 3'b000, 0, 0, 0, 15);
        ex(qr + 16, 0, "a_wd_fire", 3'b000, 0, 0, 1, 16);
        ex(qr + 25, 0, "a_wd_stable", 3'b000, 0, 0, 1, 16);
        ex(p, 0, "a_soft_from_timeout", 3'b111, 1, 0, 0, 0);
        ex(q2 + 15, 0, "a_tie_pre", 3'b000, 0, 0, 0, 15);
        ex(q2 + 16, 0, "a_tie_halt_wins", 3'b000, 0, 1, 0, 16);
        ex(q2 + 20, 0, "a_tie_stable", 3'b000, 0, 1, 0, 16);
        ex(z - 1, 0, "a_before_rst_soft", 3'b000, 0, 1, 0, 16);
        ex(z - 1, 1, "b_before_rst", 3'b000, 0, 0, 0, 15);
        ex(z, 0, "a_rst_and_soft", 3'b111, 1, 0, 0, 0);
        ex(z, 1, "b_rst", 3'b001, 1, 0, 0, 0);
        ex(z + 4, 0, "a_after_rst_ch0", 3'b110, 1, 0, 0, 0);

        goto(r);          rst = 1'b0;
        goto(r + 1);      halt_a = 1'b1;
        goto(r + 2);      halt_a = 1'b0;
        goto(r + 17);     halt_a = 1'b1;
        goto(r + 18);     halt_a = 1'b0;
        goto(s - 1);      soft_a = 1'b1;
        goto(s);          soft_a = 1'b0;
        goto(s2 - 1);     soft_a = 1'b1;
        goto(s2);         soft_a = 1'b0;
        goto(p - 1);      soft_a = 1'b1;
        goto(p);          soft_a = 1'b0;
        goto(q2 + 15);    halt_a = 1'b1;
        goto(q2 + 16);    halt_a = 1'b0;
        goto(z - 1);      rst = 1'b1; soft_a = 1'b1;
        goto(z);          rst = 1'b0; soft_a = 1'b0;
        goto(z + 6);

        foreach (q[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expected at edge %0d but never checked", q[i].name, q[i].edge_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
